serial_adder: RTL

Bit-serial, parametrised add/subtract unit built from one full-adder slice and a carry flip-flop. It processes one bit per clock, LSB first, and returns a WIDTH-bit sum with carry-out and signed overflow. It is the sequential successor to the combinational half/full adders. It sits in the datapath where area matters more than latency, with a start/done handshake toward the controlling sequencer.

---
 rtl/serial_adder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder slice plus a carry flop, LSB first.
// A start/done handshake frames each WIDTH-cycle operation; results hold until the next MSB step.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic bit_s;
    logic bit_c;

    // The single full-adder slice, fed from the LSBs of the operand shifters.
    assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    a_sh_d   = a;
                    b_sh_d   = sub ? ~b : b;
                    carry_d  = sub | cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = bit_c;
                sum_sh_d = (WIDTH-1)'({bit_s, sum_sh_q} >> 1);
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // MSB step: the carry entering this slice is c_msb, bit_c is the carry-out.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = {bit_s, sum_sh_q};
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the datapath shifters are plain flops, not a memory, so they are cleared with the rest.
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
